// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, opcode field layout and fetch-state enum
package cpu_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 26;

  localparam int OPC_HI = 25;
  localparam int OPC_LO = 22;
  localparam logic [OPC_HI-OPC_LO:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with load and wrapping increment
module pc_reg #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Load beats increment; increment wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (load)
      pc_d = load_val;
    else if (inc)
      pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc_q <= '0;
    else
      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch FSM presenting instr_mem words to decode via valid/ready
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  prog_pointer,
  input  logic [INSTR_W-1:0] opcode,
  output logic               mem_we,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted,
  output logic [7:0]         fetch_count
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] instr_out_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               instr_valid_q;
  logic               halted_q;
  logic [7:0]         fetch_count_q;

  logic [ADDR_W-1:0]  pc;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_val;
  logic               pc_inc;
  logic               capture;
  logic               is_halt;

  assign capture = !instr_valid_q || instr_ready;
  assign is_halt = (opcode[OPC_HI:OPC_LO] == OP_HALT);

  // A captured HALT word leaves the PC parked on itself.
  always_comb begin
    pc_load     = 1'b0;
    pc_load_val = '0;
    pc_inc      = 1'b0;
    if (state_q == S_IDLE) begin
      pc_load = start;
    end else if (branch_valid) begin
      pc_load     = 1'b1;
      pc_load_val = branch_target;
    end else if (state_q == S_RUN && capture && !is_halt) begin
      pc_inc = 1'b1;
    end
  end

  pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start)
            state_q <= S_RUN;
        end
        S_RUN: begin
          if (branch_valid) begin
            instr_valid_q <= 1'b0;
          end else if (capture) begin
            instr_out_q   <= opcode;
            instr_pc_q    <= pc;
            instr_valid_q <= 1'b1;
            if (fetch_count_q != 8'hFF)
              fetch_count_q <= fetch_count_q + 8'd1;
            if (is_halt) begin
              state_q  <= S_HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          if (branch_valid) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_RUN;
            halted_q      <= 1'b0;
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign prog_pointer = pc;
  assign mem_we       = 1'b0;
  assign instr_out    = instr_out_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = instr_valid_q;
  assign halted       = halted_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the read side of `instr_mem`, the counterpart to the bench/loader that writes it. It owns the program counter and drives `prog_pointer`. It samples the 26-bit `opcode` that `instr_mem` returns combinationally and presents each instruction to the decode stage through a valid/ready handshake. It handles branch redirects and a HALT opcode, and sits between `instr_mem` and the decoder in the CPU datapath.

## Interface
- `ADDR_W`, 4: program-counter and memory-address width; memory depth is 2^ADDR_W.
- `INSTR_W`, 26: instruction width.
- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins fetching from address 0 when in IDLE.
- `prog_pointer`  out  ADDR_W  address to `instr_mem`; equals the PC register.
- `opcode`  in  INSTR_W  instruction word from `instr_mem`; combinational read of `prog_pointer`.
- `mem_we`  out  1  drives `instr_mem` write strobe; constant 0.
- `branch_valid`  in  1  redirect request from execute.
- `branch_target`  in  ADDR_W  redirect address.
- `instr_out`  out  INSTR_W  registered instruction to decode.
- `instr_pc`  out  ADDR_W  address `instr_out` was fetched from.
- `instr_valid`  out  1  `instr_out` holds an unconsumed instruction.
- `instr_ready`  in  1  decode accepts `instr_out` this cycle.
- `halted`  out  1  high in the HALTED state.
- `fetch_count`  out  8  number of instructions captured; saturates at 255.

## Operation
- States: IDLE, RUN, HALTED.
- Reset values: state IDLE, PC 0, `instr_out` 0, `instr_pc` 0, `instr_valid` 0, `halted` 0, `fetch_count` 0.
- IDLE: `start` moves the state to RUN with PC 0. No fetch occurs in the `start` cycle. Redirects are ignored in IDLE.
- RUN, capture condition: `!instr_valid || instr_ready`. On capture:
  - `instr_out` is loaded from `opcode` and `instr_pc` from PC.
  - `instr_valid` is set to 1 and `fetch_count` is incremented (saturating).
  - PC becomes PC+1 modulo 2^ADDR_W, so 15 wraps to 0.
- RUN, stall: when `instr_valid && !instr_ready`, all registers hold.
- HALT: an instruction whose `opcode[25:22]` equals `OP_HALT` (4'hF) is captured normally. PC does not advance and the state moves to HALTED. The HALT word stays visible until it is consumed.
- HALTED: no fetch. `instr_valid` clears when `instr_ready` is seen.
- Redirect: `branch_valid` in RUN or HALTED has priority over capture and stall. It sets PC to `branch_target`, clears `instr_valid` (wrong-path instruction discarded), and sets the state to RUN. No capture occurs in that cycle.
- `start` outside IDLE is ignored. Simultaneous `start` and `branch_valid` in IDLE: `start` wins, PC 0.

## Timing
- `start` sampled at edge N → RUN. Edge N+1 captures mem[0] and `instr_valid` is 1 after it.
- Steady state with `instr_ready` high: one instruction per cycle, zero bubbles.
- Redirect sampled at edge N → `instr_valid` is 0 after N. Edge N+1 captures mem[`branch_target`]. This is a one-cycle bubble.
- `prog_pointer` changes only after clock edges, so `opcode` has a full cycle to settle.
- `reset` asserted at any time, including mid-stall or in HALTED, forces reset values immediately without waiting for a clock edge.

## Structure
- Shared package `cpu_pkg` holds:
  - `INSTR_W` and `ADDR_W` defaults.
  - The opcode field slice 25:22 and `OP_HALT` = 4'hF.
  - The fetch-state enum IDLE/RUN/HALTED.
- One sub-module, `pc_reg`: the ADDR_W-bit PC with load (redirect/start) and increment-with-wrap, and asynchronous reset to 0.
- The FSM, output register and counter live in `instr_fetch`.

## Test plan
- Preload mem[i]=26'h0000100+i, pulse `start`, hold `instr_ready`=1 → `instr_out` sequence 0000100..000010F, then wraps to 0000100 with `instr_pc` 0. `fetch_count`=17 after 17 captures.
- Hold `instr_ready`=0 for 3 cycles after the first capture → `instr_out`=0000100 and `prog_pointer`=1 stay stable. The next word appears one cycle after ready returns.
- Assert `branch_valid`, target 9, while `instr_valid`=1 → `instr_valid`=0 for one cycle, then `instr_out`=mem[9] with `instr_pc`=9.
- mem[3]=26'h3C00000 (HALT) → instructions 0–3 delivered, then `halted`=1 and `prog_pointer` stays 3. After the consume, `instr_valid`=0. A branch to 0 resumes with mem[0].
- Assert `reset` asynchronously mid-stall → all outputs take reset values before the next edge. A `start` pulse then fetches mem[0].
- Run 300 captures → `fetch_count` saturates at 255, and `mem_we` is 0 throughout.
